// File: rtl/clk_div_ctrl_pkg.sv
// Shared definitions for the clock-divider configuration controller.
//   DIV_W              : divider ratio width
//   TIMEOUT_CYCLES_DEF : default per-phase handshake timeout
//   clk_div_ctrl_state_e : controller FSM states
//   idx_w()            : index width for an N-entry requester vector
package clk_div_ctrl_pkg;

    localparam int DIV_W              = 8;
    localparam int TIMEOUT_CYCLES_DEF = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SET  = 2'd1,
        CLR  = 2'd2,
        SKIP = 2'd3
    } clk_div_ctrl_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_cfg_ctrl_if.sv
// Asynchronous configuration port of one clock_divider instance.
//   data  : ratio presented to the divider (clk_div_data_o)
//   valid : request level, 4-phase handshake (clk_div_valid_o)
//   ack   : divider acknowledge, asynchronous to the controller (clk_div_ack_i)
// master = controller side, slave = divider side.
interface clk_div_cfg_ctrl_if;
    import clk_div_ctrl_pkg::*;

    logic [DIV_W-1:0] data;
    logic             valid;
    logic             ack;

    modport master (output data, output valid, input ack);
    modport slave  (input data, input valid, output ack);
endinterface

// File: rtl/clk_div_ctrl_rr_arb.sv
// Round-robin arbiter for the divider configuration requesters.
//   req : request vector
//   en  : grant is being taken this cycle; advances the pointer
//   gnt : one-hot winner (combinational)
//   idx : binary index of the winner
// The pointer moves to winner+1 so the last winner has lowest priority next time.
module clk_div_ctrl_rr_arb
    import clk_div_ctrl_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             found;
    int               k;

    // Scan starting at the pointer; first set request wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = (int'(ptr_q) + i) % NUM_REQ;
            if (!found && req[k]) begin
                found  = 1'b1;
                idx    = IDX_W'(k);
                gnt[k] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (en && found) begin
            ptr_d = (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end

endmodule

// File: rtl/pulp_sync.sv
// Multi-flop synchronizer for a single asynchronous level.
//   clk_i, rstn_i : destination clock, async active-low reset
//   serial_i      : asynchronous input
//   serial_o      : synchronized output (STAGES cycles of latency)
// RESET_VAL selects the level the chain assumes while in reset.
module pulp_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic serial_i,
    output logic serial_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], serial_i};
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) sync_q <= {STAGES{RESET_VAL}};
        else         sync_q <= sync_d;
    end

    assign serial_o = sync_q[STAGES-1];

endmodule

// File: rtl/clk_div_cfg_ctrl.sv
// Divider-ratio update sequencer: arbitrates requesters round-robin and drives
// the 4-phase valid/ack handshake of one clock_divider.
//   clk_i, rstn_i : controller clock, async active-low reset
//   req_i / div_i : per-requester request level and ratio
//   gnt_o / done_o: per-requester grant and completion pulses
//   err_o         : qualifies done_o, handshake timed out
//   busy_o        : transaction in flight
//   cur_div_o     : last committed ratio
//   div_if        : divider port (clk_div_data_o, clk_div_valid_o, clk_div_ack_i)
// Optional feature: define CLK_DIV_CTRL_TIMEOUT_EN for per-phase timeouts.
module clk_div_cfg_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int               NUM_REQ        = 2,
    parameter logic [DIV_W-1:0] DIV_INIT       = '0,
    parameter int               TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic [NUM_REQ-1:0]             req_i,
    input  logic [NUM_REQ-1:0][DIV_W-1:0]  div_i,
    output logic [NUM_REQ-1:0]             gnt_o,
    output logic [NUM_REQ-1:0]             done_o,
    output logic                           err_o,
    output logic                           busy_o,
    output logic [DIV_W-1:0]               cur_div_o,
    clk_div_cfg_ctrl_if.master             div_if
);

    localparam int IDX_W = idx_w(NUM_REQ);

    if (NUM_REQ < 1 || NUM_REQ > 8) begin : g_bad_num_req
        $error("clk_div_cfg_ctrl: NUM_REQ must be 1..8");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("clk_div_cfg_ctrl: TIMEOUT_CYCLES must be >= 2");
    end

    clk_div_ctrl_state_e state_q, state_d;
    logic [DIV_W-1:0]    data_q, data_d;
    logic [DIV_W-1:0]    cur_div_q, cur_div_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic                valid_q, valid_d;
    logic                ack_s;
    logic                grant;
    logic                complete;
    logic [NUM_REQ-1:0]  arb_gnt;
    logic [IDX_W-1:0]    arb_idx;
    logic                phase_to;
    logic                err_q;

    // Sync chain resets to 1: after reset no grant is issued until the divider
    // has been seen with ack low, so a stale ack cannot close a new handshake.
    pulp_sync #(.STAGES(2), .RESET_VAL(1'b1)) i_ack_sync (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .serial_i (div_if.ack),
        .serial_o (ack_s)
    );

    assign grant = (state_q == IDLE) && (|req_i) && !ack_s;

    clk_div_ctrl_rr_arb #(.NUM_REQ(NUM_REQ)) i_arb (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .req    (req_i),
        .en     (grant),
        .gnt    (arb_gnt),
        .idx    (arb_idx)
    );

`ifdef CLK_DIV_CTRL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_d;

    assign phase_to = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counter restarts on every state change, so it measures time in the
    // current SET or CLR phase only.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (state_d != state_q || !(state_q inside {SET, CLR})) cnt_d = '0;
        err_d = err_q;
        if (grant)                                      err_d = 1'b0;
        else if (state_q == SET && !ack_s && phase_to)  err_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`else
    assign phase_to = 1'b0;
    assign err_q    = 1'b0;
`endif

    // State register and datapath flops
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            data_q    <= '0;
            cur_div_q <= DIV_INIT;
            owner_q   <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            cur_div_q <= cur_div_d;
            owner_q   <= owner_d;
            valid_q   <= valid_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (grant) state_d = (div_i[arb_idx] == cur_div_q) ? SKIP : SET;
            SET:  if (ack_s || phase_to) state_d = CLR;
            CLR:  if (!ack_s || phase_to) state_d = IDLE;
            SKIP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: data only moves on a grant, so it is stable across the handshake.
    always_comb begin
        data_d    = data_q;
        owner_d   = owner_q;
        cur_div_d = cur_div_q;
        if (grant) begin
            data_d  = div_i[arb_idx];
            owner_d = arb_idx;
        end
        if (state_q == CLR && !ack_s && !err_q) cur_div_d = data_q;
        valid_d = (state_d == SET);
    end

    // Outputs
    always_comb begin
        gnt_o    = grant ? arb_gnt : '0;
        complete = (state_q == SKIP) || (state_q == CLR && (!ack_s || phase_to));
        for (int i = 0; i < NUM_REQ; i++) begin
            done_o[i] = complete && (owner_q == IDX_W'(i));
        end
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
        // ack still high when CLR ends means CLR itself timed out.
        err_o = complete && (state_q == CLR) && (err_q || ack_s);
`else
        err_o = 1'b0;
`endif
        busy_o = (state_q != IDLE);
    end

    assign cur_div_o    = cur_div_q;
    assign div_if.data  = data_q;
    assign div_if.valid = valid_q;

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
module tb_clk_div_cfg_ctrl;
    import clk_div_ctrl_pkg::*;

    localparam int N  = 2;
    localparam int TO = 16;

    logic                      clk = 1'b0;
    logic                      rstn;
    logic [N-1:0]              req;
    logic [N-1:0][DIV_W-1:0]   div;
    logic [N-1:0]              gnt, done;
    logic                      err, busy;
    logic [DIV_W-1:0]          cur_div;
    logic                      ack_m;

    clk_div_cfg_ctrl_if dif ();
    assign dif.ack = ack_m;

    clk_div_cfg_ctrl #(.NUM_REQ(N), .DIV_INIT(8'h00), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i     (clk),
        .rstn_i    (rstn),
        .req_i     (req),
        .div_i     (div),
        .gnt_o     (gnt),
        .done_o    (done),
        .err_o     (err),
        .busy_o    (busy),
        .cur_div_o (cur_div),
        .div_if    (dif)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference state: round-robin pointer and last committed ratio
    int               m_ptr;
    logic [DIV_W-1:0] m_cur;

    // Divider model: 0 = auto ack after ack_dly cycles, 1 = never ack, 2 = manual
    int mode    = 0;
    int ack_dly = 3;
    int mcnt    = 0;

    initial begin
        ack_m = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mode == 0) begin
                if (dif.valid !== ack_m) begin
                    if (mcnt >= ack_dly) begin
                        ack_m = dif.valid;
                        mcnt  = 0;
                    end else mcnt++;
                end else mcnt = 0;
            end
        end
    end

    // Data stability monitor: no change from a cycle where valid or ack_s may be high
    int               stab_err  = 0;
    logic [DIV_W-1:0] prev_data = '0;
    bit               prev_prot = 0;
    logic [2:0]       ackh      = '0;
    always @(negedge clk) begin
        ackh = {ackh[1:0], ack_m};
        if (!rstn) prev_prot = 0;
        else begin
            if (prev_prot && dif.data !== prev_data) stab_err++;
            prev_prot = dif.valid || (|ackh);
        end
        prev_data = dif.data;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input int ptr, input logic [N-1:0] r);
        for (int i = 0; i < N; i++) if (r[(ptr + i) % N]) return (ptr + i) % N;
        return -1;
    endfunction

    task automatic do_reset();
        rstn = 1'b0;
        req  = '0;
        div  = '0;
        mode = 0;
        @(negedge clk);
        chk("rst_gnt",   32'(gnt), 0);
        chk("rst_done",  32'(done), 0);
        chk("rst_err",   32'(err), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_valid", 32'(dif.valid), 0);
        chk("rst_data",  32'(dif.data), 0);
        chk("rst_cur",   32'(cur_div), 32'h00);
        @(negedge clk);
        rstn  = 1'b1;
        m_ptr = 0;
        m_cur = 8'h00;
    endtask

    task automatic get_grant(output int w, output bit got, output int cyc);
        got = 0; w = 0; cyc = 0;
        #1;
        for (int c = 0; c < 300; c++) begin
            if (gnt != 0) begin got = 1; break; end
            @(negedge clk);
            cyc++;
        end
        chk("gnt_seen", 32'(got), 1);
        if (got) begin
            w = rr_pick(m_ptr, req);
            if (w < 0) w = 0;
            chk("gnt_vec", 32'(gnt), 32'(1) << w);
            m_ptr = (w + 1) % N;
        end
    endtask

    task automatic finish(input int w, input bit exp_err, output int vcnt);
        bit skip, got, vseen;
        int lat;
        skip = (div[w] == m_cur) && !exp_err;
        got = 0; vseen = 0; lat = 0; vcnt = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            lat++;
            if (lat == 1) chk("gnt_pulse", 32'(gnt), 0);
            if (dif.valid) begin vseen = 1; vcnt++; end
            if (done != 0) begin got = 1; break; end
        end
        chk("done_seen", 32'(got), 1);
        chk("done_vec", 32'(done), 32'(1) << w);
        chk("done_err", 32'(err), 32'(exp_err));
        chk("valid_seen", 32'(vseen), 32'(!skip));
        if (skip) chk("skip_lat", 32'(lat), 1);
        if (!skip && !exp_err && got) m_cur = div[w];
        req[w] = 1'b0;
        @(negedge clk);
        chk("cur_div", 32'(cur_div), 32'(m_cur));
        chk("busy_idle", 32'(busy), 0);
    endtask

    task automatic serve();
        int w, cyc, vc;
        bit got;
        while (req != 0) begin
            get_grant(w, got, cyc);
            if (!got) begin req = '0; return; end
            finish(w, 1'b0, vc);
        end
    endtask

    initial begin
        int w, cyc, vc;
        bit got, any_g;
        logic [N-1:0] mask;

        rstn = 1'b0;
        req  = '0;
        div  = '0;
        do_reset();

        // Single request, ack after 3 cycles
        ack_dly = 3;
        div[0]  = 8'h04;
        req     = 2'b01;
        serve();
        chk("single_cur", 32'(cur_div), 32'h04);

        // Contention from a fresh reset, then a second burst
        do_reset();
        div = {8'h09, 8'h05};
        req = 2'b11;
        serve();
        chk("contention_cur", 32'(cur_div), 32'h09);
        div = {8'h21, 8'h12};
        req = 2'b11;
        serve();

        // Same value as current ratio: no handshake
        div[0] = m_cur;
        req    = 2'b01;
        serve();

        // Reset in SET with the divider holding ack high
        mode   = 2;
        ack_m  = 1'b0;
        div[0] = 8'h33;
        req    = 2'b01;
        get_grant(w, got, cyc);
        @(negedge clk);
        chk("midset_valid", 32'(dif.valid), 1);
        ack_m = 1'b1;
        @(negedge clk);
        rstn = 1'b0;
        req  = '0;
        #1;
        chk("rst_valid_async", 32'(dif.valid), 0);
        chk("rst_busy_async", 32'(busy), 0);
        @(negedge clk);
        @(negedge clk);
        rstn   = 1'b1;
        m_ptr  = 0;
        m_cur  = 8'h00;
        div[1] = 8'h44;
        req    = 2'b10;
        any_g  = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (gnt != 0) any_g = 1;
        end
        chk("stale_ack_hold", 32'(any_g), 0);
        ack_m = 1'b0;
        get_grant(w, got, cyc);
        chk("ack_low_wait", 32'(cyc >= 2), 1);
        mode = 0;
        if (got) finish(w, 1'b0, vc);

`ifdef CLK_DIV_CTRL_TIMEOUT_EN
        // Divider never answers: SET times out, then CLR completes with error
        mode   = 1;
        div[1] = m_cur ^ 8'h5A;
        req    = 2'b10;
        get_grant(w, got, cyc);
        if (got) begin
            finish(w, 1'b1, vc);
            chk("timeout_valid_len", 32'(vc), TO);
        end
        mode = 0;
`endif

        // Randomized rounds
        for (int r = 0; r < 40; r++) begin
            ack_dly = $urandom_range(0, 20);
            mask    = N'($urandom_range(1, 3));
            for (int i = 0; i < N; i++) begin
                div[i] = ($urandom_range(0, 3) == 0) ? m_cur : DIV_W'($urandom);
            end
            req = mask;
            serve();
        end

        chk("data_stable", 32'(stab_err), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
